// File: rtl/hd_chan_pkg.sv
// Shared types, constants and helpers for the Hamming error-injection channel.
package hd_chan_pkg;

  typedef enum logic [1:0] {
    RANDOM = 2'd0,
    FIXED  = 2'd1,
    BURST  = 2'd2,
    RSVD   = 2'd3
  } err_mode_e;

  typedef enum logic [1:0] {
    IDLE,
    PICK,
    HOLD
  } chan_state_e;

  // Galois form of x^32 + x^22 + x^2 + x + 1 for a right-shifting register.
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [31:0] CNT_MAX   = 32'hFFFF_FFFF;

  function automatic logic [31:0] popcount(input logic [63:0] vec);
    logic [31:0] cnt;
    cnt = '0;
    for (int i = 0; i < 64; i++) cnt = cnt + 32'(vec[i]);
    return cnt;
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] lhs, input logic [31:0] rhs);
    logic [32:0] sum;
    sum = {1'b0, lhs} + {1'b0, rhs};
    return sum[32] ? CNT_MAX : sum[31:0];
  endfunction

endpackage

// File: rtl/hd_lfsr.sv
// Galois LFSR with step enable; a zero seed is promoted to 1 so it cannot lock up.
module hd_lfsr #(
  parameter int              W     = 32,
  parameter logic [W-1:0]    SEED  = {{(W-1){1'b0}}, 1'b1},
  parameter logic [W-1:0]    TAPS  = hd_chan_pkg::LFSR_TAPS,
  parameter int              OUT_W = W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  output logic [OUT_W-1:0] rnd_o
);

  localparam logic [W-1:0] SEED_NZ = (SEED == '0) ? {{(W-1){1'b0}}, 1'b1} : SEED;

  logic [W-1:0] state_q, state_d;

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (en_i) state_d = state_q[0] ? ((state_q >> 1) ^ TAPS) : (state_q >> 1);
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= SEED_NZ;
    else        state_q <= state_d;
  end

  assign rnd_o = state_q[OUT_W-1:0];

endmodule

// File: rtl/hd_err_inject_chan.sv
// Valid/ready noisy channel: flips fixed, burst or LFSR-chosen distinct bits of each codeword.
module hd_err_inject_chan
  import hd_chan_pkg::*;
#(
  parameter int                K      = 11,
  parameter int                M      = 4,
  parameter int                IDX_W  = $clog2(K+M),
  parameter int                LFSR_W = 32,
  parameter logic [LFSR_W-1:0] SEED   = 32'hACE1_2022
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [K+M-1:0]   cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [K+M-1:0]   cout_err,
  output logic [K+M-1:0]   err_mask,
  input  logic [1:0]       num_errs,
  input  logic [1:0]       error_mode,
  input  logic [IDX_W-1:0] err_pos_0,
  input  logic [IDX_W-1:0] err_pos_1,
  input  logic [IDX_W-1:0] err_pos_2,
  input  logic [15:0]      err_period,
  output logic [31:0]      word_cnt,
  output logic [31:0]      bit_err_cnt
);

  localparam int           N     = K + M;
  localparam int           EXT_W = 2 ** IDX_W;
  localparam logic [N-1:0] ONE   = {{(N-1){1'b0}}, 1'b1};

  chan_state_e      state_q, state_d;
  logic [N-1:0]     cin_q, cin_d;
  logic [1:0]       num_q, num_d;
  logic [N-1:0]     mask_q, mask_d;
  logic [1:0]       picks_q, picks_d;
  logic [N-1:0]     cout_q, cout_d;
  logic [N-1:0]     emask_q, emask_d;
  logic [31:0]      wcnt_q, wcnt_d;
  logic [31:0]      bcnt_q, bcnt_d;
  logic [15:0]      per_q, per_d;

  logic             lfsr_en;
  logic [IDX_W-1:0] cand;
  logic [EXT_W-1:0] mask_ext;
  logic             cand_ok;
  logic [N-1:0]     fixed_mask, burst_mask;
  logic [15:0]      period_eff;
  logic [16:0]      per_inc;
  logic             go_hold;
  logic [N-1:0]     hold_src, hold_mask;
  err_mode_e        mode;

  hd_lfsr #(
    .W     (LFSR_W),
    .SEED  (SEED),
    .TAPS  (LFSR_TAPS),
    .OUT_W (IDX_W)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (lfsr_en),
    .rnd_o (cand)
  );

  assign mode       = err_mode_e'(error_mode);
  assign mask_ext   = EXT_W'(mask_q);
  assign cand_ok    = (int'(cand) < N) && !mask_ext[cand];
  assign period_eff = (err_period == 16'd0) ? 16'd1 : err_period;
  assign per_inc    = {1'b0, per_q} + 17'd1;

  // Shifting ONE by a position >= N drops it, so out-of-range fixed positions add nothing.
  always_comb begin
    int b;
    b          = 0;
    fixed_mask = '0;
    burst_mask = '0;
    if (num_errs >= 2'd1) fixed_mask = fixed_mask | (ONE << err_pos_0);
    if (num_errs >= 2'd2) fixed_mask = fixed_mask | (ONE << err_pos_1);
    if (num_errs == 2'd3) fixed_mask = fixed_mask | (ONE << err_pos_2);
    if (int'(err_pos_0) < N) begin
      for (int j = 0; j < 3; j++) begin
        if (j < int'(num_errs)) begin
          b = int'(err_pos_0) + j;
          if (b >= N) b = b - N;
          burst_mask = burst_mask | (ONE << b);
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cin_d     = cin_q;
    num_d     = num_q;
    mask_d    = mask_q;
    picks_d   = picks_q;
    cout_d    = cout_q;
    emask_d   = emask_q;
    wcnt_d    = wcnt_q;
    bcnt_d    = bcnt_q;
    per_d     = per_q;
    lfsr_en   = 1'b0;
    go_hold   = 1'b0;
    hold_src  = '0;
    hold_mask = '0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          cin_d  = cin;
          num_d  = num_errs;
          wcnt_d = sat_add(wcnt_q, 32'd1);
          per_d  = (per_inc >= {1'b0, period_eff}) ? 16'd0 : per_inc[15:0];
          if (per_q != 16'd0 || num_errs == 2'd0 || mode == RSVD) begin
            go_hold  = 1'b1;
            hold_src = cin;
          end else if (mode == FIXED) begin
            go_hold   = 1'b1;
            hold_src  = cin;
            hold_mask = fixed_mask;
          end else if (mode == BURST) begin
            go_hold   = 1'b1;
            hold_src  = cin;
            hold_mask = burst_mask;
          end else begin
            mask_d  = '0;
            picks_d = '0;
            state_d = PICK;
          end
        end
      end
      PICK: begin
        lfsr_en = 1'b1;
        if (cand_ok) begin
          mask_d  = mask_q | (ONE << cand);
          picks_d = picks_q + 2'd1;
          if ((picks_q + 2'd1) == num_q) begin
            go_hold   = 1'b1;
            hold_src  = cin_q;
            hold_mask = mask_d;
          end
        end
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (go_hold) begin
      state_d = HOLD;
      cout_d  = hold_src ^ hold_mask;
      emask_d = hold_mask;
      bcnt_d  = sat_add(bcnt_q, popcount(64'(hold_mask)));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cin_q   <= '0;
      num_q   <= '0;
      mask_q  <= '0;
      picks_q <= '0;
      cout_q  <= '0;
      emask_q <= '0;
      wcnt_q  <= '0;
      bcnt_q  <= '0;
      per_q   <= '0;
    end else begin
      state_q <= state_d;
      cin_q   <= cin_d;
      num_q   <= num_d;
      mask_q  <= mask_d;
      picks_q <= picks_d;
      cout_q  <= cout_d;
      emask_q <= emask_d;
      wcnt_q  <= wcnt_d;
      bcnt_q  <= bcnt_d;
      per_q   <= per_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == HOLD);
  assign cout_err    = cout_q;
  assign err_mask    = emask_q;
  assign word_cnt    = wcnt_q;
  assign bit_err_cnt = bcnt_q;

endmodule

// File: tb/tb_hd_err_inject_chan.sv
// Directed bench for hd_err_inject_chan: reset, passthrough, fixed, burst, period/backpressure, random, mid-PICK reset.
module tb_hd_err_inject_chan;

  localparam int          K     = 11;
  localparam int          M     = 4;
  localparam int          N     = K + M;
  localparam int          IDX_W = 4;
  localparam logic [31:0] SEED  = 32'hACE1_2022;
  localparam logic [31:0] TAPS  = 32'h8020_0003;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [N-1:0]     cin = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [N-1:0]     cout_err;
  logic [N-1:0]     err_mask;
  logic [1:0]       num_errs = '0;
  logic [1:0]       error_mode = '0;
  logic [IDX_W-1:0] err_pos_0 = '0;
  logic [IDX_W-1:0] err_pos_1 = '0;
  logic [IDX_W-1:0] err_pos_2 = '0;
  logic [15:0]      err_period = 16'd1;
  logic [31:0]      word_cnt;
  logic [31:0]      bit_err_cnt;

  int          total = 0;
  int          bad = 0;
  logic [31:0] m_lfsr;
  logic [N-1:0] first_masks [20];

  always #5 clk = ~clk;

  hd_err_inject_chan dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .cin         (cin),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .cout_err    (cout_err),
    .err_mask    (err_mask),
    .num_errs    (num_errs),
    .error_mode  (error_mode),
    .err_pos_0   (err_pos_0),
    .err_pos_1   (err_pos_1),
    .err_pos_2   (err_pos_2),
    .err_period  (err_period),
    .word_cnt    (word_cnt),
    .bit_err_cnt (bit_err_cnt)
  );

  // Callers are always positioned 1 time unit after a rising edge.
  task automatic apply_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Offers one word, scrambles the config ports right after acceptance, waits for out_valid.
  task automatic send(input logic [N-1:0] c, input logic [1:0] mode, input logic [1:0] num,
                      input logic [IDX_W-1:0] p0, input logic [IDX_W-1:0] p1, input logic [IDX_W-1:0] p2,
                      output logic [N-1:0] mask, output logic [N-1:0] cout, output int lat);
    int guard;
    in_valid = 1'b1; cin = c; error_mode = mode; num_errs = num;
    err_pos_0 = p0; err_pos_1 = p1; err_pos_2 = p2; out_ready = 1'b0;
    guard = 0;
    while (!in_ready && guard < 100) begin @(posedge clk); #1; guard++; end
    @(posedge clk); #1;
    in_valid = 1'b0; cin = ~c; num_errs = 2'd0; error_mode = ~mode;
    err_pos_0 = ~p0; err_pos_1 = ~p1; err_pos_2 = ~p2;
    lat = 1;
    while (!out_valid && lat < 300) begin @(posedge clk); #1; lat++; end
    total++;
    if (out_valid !== 1'b1) begin
      bad++; $display("FAIL handshake_timeout out_valid=%b want 1", out_valid);
    end
    mask = err_mask;
    cout = cout_err;
  endtask

  task automatic release_word();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // Reference picker: current LFSR low bits are the candidate, register steps every attempt.
  task automatic model_random(input int num, output logic [N-1:0] mask, output int attempts);
    int picks;
    logic [IDX_W-1:0] c;
    mask = '0; picks = 0; attempts = 0;
    while (picks < num) begin
      c = m_lfsr[IDX_W-1:0];
      if (int'(c) < N && !mask[c]) begin mask[c] = 1'b1; picks++; end
      m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ TAPS) : (m_lfsr >> 1);
      attempts++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    total++; if (cout_err !== '0 || err_mask !== '0) begin
      bad++; $display("FAIL reset_outputs cout=%h mask=%h want 0", cout_err, err_mask); end
    total++; if (word_cnt !== 32'd0 || bit_err_cnt !== 32'd0) begin
      bad++; $display("FAIL reset_counters words=%0d bits=%0d want 0", word_cnt, bit_err_cnt); end
    rst_n = 1'b1;
  endtask

  task automatic test_passthrough();
    logic [N-1:0] m, c; int lat;
    err_period = 16'd1;
    send(15'h2A5C, 2'd1, 2'd0, 4'd3, 4'd4, 4'd5, m, c, lat);
    total++; if (c !== 15'h2A5C) begin bad++; $display("FAIL pass_cout got %h want 2a5c", c); end
    total++; if (m !== 15'h0) begin bad++; $display("FAIL pass_mask got %h want 0", m); end
    total++; if (lat != 1) begin bad++; $display("FAIL pass_latency got %0d want 1", lat); end
    total++; if (bit_err_cnt !== 32'd0) begin bad++; $display("FAIL pass_bitcnt got %0d want 0", bit_err_cnt); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL pass_in_ready_hold got %b want 0", in_ready); end
    release_word();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL pass_in_ready_idle got %b want 1", in_ready); end
  endtask

  task automatic test_fixed();
    logic [N-1:0] m, c; int lat;
    send(15'h0000, 2'd1, 2'd3, 4'd0, 4'd4, 4'd14, m, c, lat);
    total++; if (m !== 15'h4011 || c !== 15'h4011) begin
      bad++; $display("FAIL fixed_a mask=%h cout=%h want 4011/4011", m, c); end
    total++; if (bit_err_cnt !== 32'd3) begin bad++; $display("FAIL fixed_a_bitcnt got %0d want 3", bit_err_cnt); end
    release_word();
    send(15'h0000, 2'd1, 2'd3, 4'd2, 4'd2, 4'd5, m, c, lat);
    total++; if (m !== 15'h0024) begin bad++; $display("FAIL fixed_dup mask=%h want 0024", m); end
    total++; if (bit_err_cnt !== 32'd5) begin bad++; $display("FAIL fixed_dup_bitcnt got %0d want 5", bit_err_cnt); end
    release_word();
    send(15'h7FFF, 2'd1, 2'd2, 4'd15, 4'd3, 4'd1, m, c, lat);
    total++; if (m !== 15'h0008 || c !== 15'h7FF7) begin
      bad++; $display("FAIL fixed_oob mask=%h cout=%h want 0008/7ff7", m, c); end
    total++; if (bit_err_cnt !== 32'd6) begin bad++; $display("FAIL fixed_oob_bitcnt got %0d want 6", bit_err_cnt); end
    release_word();
  endtask

  task automatic test_burst();
    logic [N-1:0] m, c; int lat;
    send(15'h0000, 2'd2, 2'd3, 4'd13, 4'd0, 4'd0, m, c, lat);
    total++; if (m !== 15'h6001 || c !== 15'h6001) begin
      bad++; $display("FAIL burst_wrap mask=%h cout=%h want 6001/6001", m, c); end
    total++; if (lat != 1) begin bad++; $display("FAIL burst_latency got %0d want 1", lat); end
    release_word();
    send(15'h1111, 2'd2, 2'd2, 4'd15, 4'd0, 4'd0, m, c, lat);
    total++; if (m !== 15'h0 || c !== 15'h1111) begin
      bad++; $display("FAIL burst_oob mask=%h cout=%h want 0000/1111", m, c); end
    release_word();
    send(15'h0F0F, 2'd3, 2'd3, 4'd1, 4'd2, 4'd3, m, c, lat);
    total++; if (m !== 15'h0 || c !== 15'h0F0F) begin
      bad++; $display("FAIL rsvd_mode mask=%h cout=%h want 0000/0f0f", m, c); end
    total++; if (bit_err_cnt !== 32'd9 || word_cnt !== 32'd7) begin
      bad++; $display("FAIL burst_counters bits=%0d words=%0d want 9/7", bit_err_cnt, word_cnt); end
    release_word();
  endtask

  task automatic test_period_backpressure();
    logic [N-1:0] m, c, exp_m; int lat; logic stable;
    err_period = 16'd4;
    for (int w = 0; w < 8; w++) begin
      exp_m = (w % 4 == 0) ? 15'h0080 : 15'h0000;
      send(15'h1234, 2'd1, 2'd1, 4'd7, 4'd0, 4'd0, m, c, lat);
      total++; if (m !== exp_m || c !== (15'h1234 ^ exp_m)) begin
        bad++; $display("FAIL period_word%0d mask=%h cout=%h want %h/%h", w, m, c, exp_m, 15'h1234 ^ exp_m); end
      stable = 1'b1;
      for (int s = 0; s < 3; s++) begin
        @(posedge clk); #1;
        if (cout_err !== c || err_mask !== m || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
      end
      total++; if (stable !== 1'b1) begin
        bad++; $display("FAIL stall_stable_word%0d cout=%h valid=%b ready=%b want %h/1/0", w, cout_err, out_valid, in_ready, c); end
      release_word();
    end
    total++; if (bit_err_cnt !== 32'd11 || word_cnt !== 32'd15) begin
      bad++; $display("FAIL period_counters bits=%0d words=%0d want 11/15", bit_err_cnt, word_cnt); end
    err_period = 16'd0;
  endtask

  task automatic test_random();
    logic [N-1:0] m, c, d, exp_m; int lat, att;
    apply_reset();
    m_lfsr = SEED;
    for (int w = 0; w < 1000; w++) begin
      d = N'($urandom);
      send(d, 2'd0, 2'd3, 4'd0, 4'd0, 4'd0, m, c, lat);
      model_random(3, exp_m, att);
      total++; if ($countones(m) != 3) begin bad++; $display("FAIL rand_popcount_word%0d mask=%h want 3 bits", w, m); end
      total++; if (m !== exp_m) begin bad++; $display("FAIL rand_mask_word%0d got %h want %h", w, m, exp_m); end
      total++; if (c !== (d ^ exp_m)) begin bad++; $display("FAIL rand_cout_word%0d got %h want %h", w, c, d ^ exp_m); end
      total++; if (lat != att + 1) begin bad++; $display("FAIL rand_latency_word%0d got %0d want %0d", w, lat, att + 1); end
      if (w < 20) first_masks[w] = exp_m;
      release_word();
    end
    total++; if (word_cnt !== 32'd1000 || bit_err_cnt !== 32'd3000) begin
      bad++; $display("FAIL rand_counters words=%0d bits=%0d want 1000/3000", word_cnt, bit_err_cnt); end
    apply_reset();
    for (int w = 0; w < 20; w++) begin
      send(15'h0, 2'd0, 2'd3, 4'd0, 4'd0, 4'd0, m, c, lat);
      total++; if (m !== first_masks[w]) begin bad++; $display("FAIL rand_repro_word%0d got %h want %h", w, m, first_masks[w]); end
      release_word();
    end
  endtask

  task automatic test_reset_mid_pick();
    logic [N-1:0] m, c; int lat;
    in_valid = 1'b1; cin = 15'h5555; error_mode = 2'd0; num_errs = 2'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL pick_entry ready=%b valid=%b want 0/0", in_ready, out_valid); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL midpick_handshake valid=%b ready=%b want 0/1", out_valid, in_ready); end
    total++; if (word_cnt !== 32'd0 || bit_err_cnt !== 32'd0) begin
      bad++; $display("FAIL midpick_counters words=%0d bits=%0d want 0/0", word_cnt, bit_err_cnt); end
    rst_n = 1'b1;
    send(15'h0, 2'd0, 2'd3, 4'd0, 4'd0, 4'd0, m, c, lat);
    total++; if (m !== first_masks[0]) begin bad++; $display("FAIL midpick_lfsr_seed got %h want %h", m, first_masks[0]); end
    total++; if (word_cnt !== 32'd1) begin bad++; $display("FAIL midpick_wordcnt got %0d want 1", word_cnt); end
    release_word();
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_fixed();
    test_burst();
    test_period_backpressure();
    test_random();
    test_reset_mid_pick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
